// File: rtl/apb_cfg_pkg.sv
// Shared types for the APB configuration initiator: FSM states, arbiter register map, latched command.
package apb_cfg_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  localparam logic [CMD_ADDR_W-1:0] ARB_CTRL_ADDR   = 8'h00;
  localparam logic [CMD_ADDR_W-1:0] ARB_STATUS_ADDR = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Command captured at acceptance; widths follow the arbiter register map.
  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared before ACCESS, counts PReady-low cycles, flags the last allowed one.
module apb_wait_timer
  import apb_cfg_pkg::*;
#(
  parameter  int LIMIT = 16,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W'(LIMIT))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // The counter reaches LIMIT on the edge that ends this wait cycle.
  assign o_expired = i_en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/apb_cfg_master.sv
// APB initiator for the arbiter register port: one command at a time, SETUP -> ACCESS -> RESP.
// Optional ACCESS timeout is built in when APB_CFG_MASTER_TIMEOUT_EN is defined.
module apb_cfg_master
  import apb_cfg_pkg::*;
#(
  parameter int ADDR_W         = CMD_ADDR_W,
  parameter int DATA_W         = CMD_DATA_W,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              Pclk_i,
  input  logic              PReset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              PSel_o,
  output logic              PEnable_o,
  output logic              PWrite_o,
  output logic [ADDR_W-1:0] PAddr_o,
  output logic [DATA_W-1:0] PWData_o,
  input  logic [DATA_W-1:0] PRData_i,
  input  logic              PReady_i,
  output logic [CNT_W-1:0]  txn_cnt_o
);

  // state  | meaning
  // IDLE   | ready for a command
  // SETUP  | PSel high, PEnable low, one cycle
  // ACCESS | PSel and PEnable high until PReady (or timeout)
  // RESP   | response held until rsp_ready_i

  state_e            r_state;
  cmd_t              r_cmd;
  logic              r_psel;
  logic              r_penable;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]  r_txn_cnt;
  logic              w_accept;
  logic              w_timeout;

  assign cmd_ready_o = (r_state == ST_IDLE) && !PReset_i;
  assign w_accept    = cmd_valid_i && cmd_ready_o;

`ifdef APB_CFG_MASTER_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_en;

  assign w_tmr_clr = (r_state == ST_SETUP);
  assign w_tmr_en  = (r_state == ST_ACCESS) && !PReady_i;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk     (Pclk_i),
    .i_rst     (PReset_i),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_timeout)
  );
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge Pclk_i) begin
    if (PReset_i) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_txn_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd   <= '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
            r_psel  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PReady wins over a timeout landing in the same cycle.
          if (PReady_i || w_timeout) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !PReady_i;
            r_rsp_rdata <= (PReady_i && !r_cmd.write) ? PRData_i : '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_txn_cnt   <= r_txn_cnt + CNT_W'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PSel_o      = r_psel;
  assign PEnable_o   = r_penable;
  assign PWrite_o    = r_psel & r_cmd.write;
  assign PAddr_o     = r_psel ? r_cmd.addr  : '0;
  assign PWData_o    = r_psel ? r_cmd.wdata : '0;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign txn_cnt_o   = r_txn_cnt;

endmodule
